// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nibble_serial_subtractor                                     |
// | Description : Computes A-B one 4-bit slice per cycle, LSB slice first,     |
// |               with a valid/ready handshake on each side.                   |
// |               Optional macro SUB_COMPARE_EN adds Zero/LessThan outputs.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module nibble_serial_subtractor #(
  parameter int l = 16
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [l-1:0] D,
  output logic         Overflow,
  output logic         Borrow
`ifdef SUB_COMPARE_EN
  ,
  output logic         Zero,
  output logic         LessThan
`endif
);

  localparam int NSLICE = l / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [l-1:0]  a_q, a_d;
  logic [l-1:0]  b_q, b_d;
  logic [l-1:0]  acc_q, acc_d;
  logic [l-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d;
  logic          a_sign_q, a_sign_d;
  logic          b_sign_q, b_sign_d;
  logic          ovf_q, ovf_d;
  logic          brw_q, brw_d;
`ifdef SUB_COMPARE_EN
  logic          zero_q, zero_d;
  logic          lt_q, lt_d;
`endif

  logic [4:0]    w_slice;
  logic [l-1:0]  w_acc_next;
  logic          w_ovf;

  // Operands shift right so the active slice is always in bits [3:0];
  // result slices shift in from the top so the first lands at the bottom.
  assign w_slice    = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, ~borrow_q};
  assign w_acc_next = {w_slice[3:0], acc_q[l-1:4]};
  assign w_ovf      = (a_sign_q != b_sign_q) && (w_acc_next[l-1] != a_sign_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    ovf_d    = ovf_q;
    brw_d    = brw_q;
`ifdef SUB_COMPARE_EN
    zero_d   = zero_q;
    lt_d     = lt_q;
`endif
    case (state_q)
      IDLE: begin
        if (InValid) begin
          a_d      = A;
          b_d      = B;
          a_sign_d = A[l-1];
          b_sign_d = B[l-1];
          cnt_d    = '0;
          borrow_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> 4;
        b_d      = b_q >> 4;
        acc_d    = w_acc_next;
        borrow_d = ~w_slice[4];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_SLICE) begin
          state_d = DONE;
          d_d     = w_acc_next;
          brw_d   = ~w_slice[4];
          ovf_d   = w_ovf;
`ifdef SUB_COMPARE_EN
          zero_d  = (w_acc_next == '0);
          lt_d    = w_acc_next[l-1] ^ w_ovf;
`endif
        end
      end
      DONE: begin
        if (OutReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
      brw_q    <= 1'b0;
`ifdef SUB_COMPARE_EN
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      ovf_q    <= ovf_d;
      brw_q    <= brw_d;
`ifdef SUB_COMPARE_EN
      zero_q   <= zero_d;
      lt_q     <= lt_d;
`endif
    end
  end

  assign InReady  = (state_q == IDLE);
  assign OutValid = (state_q == DONE);
  assign D        = d_q;
  assign Overflow = ovf_q;
  assign Borrow   = brw_q;
`ifdef SUB_COMPARE_EN
  assign Zero     = zero_q;
  assign LessThan = lt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nibble_serial_subtractor                                  |
// | Description : Scoreboard bench for nibble_serial_subtractor (l=16).        |
// |               Compare flags are checked when SUB_COMPARE_EN is defined.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module tb_nibble_serial_subtractor;

  logic        Clk;
  logic        Rst_n;
  logic        InValid;
  logic        InReady;
  logic [15:0] A;
  logic [15:0] B;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] D;
  logic        Overflow;
  logic        Borrow;
`ifdef SUB_COMPARE_EN
  logic        Zero;
  logic        LessThan;
`endif

  nibble_serial_subtractor #(.l(16)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .D        (D),
    .Overflow (Overflow),
    .Borrow   (Borrow)
`ifdef SUB_COMPARE_EN
    ,
    .Zero     (Zero),
    .LessThan (LessThan)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    logic        o;
    logic        br;
    logic        z;
    logic        lt;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        o;
    logic        br;
    logic        z;
    logic        lt;
    int          acc;
  } exp_t;

  // Hand-computed vectors: a, b, d, overflow, borrow, zero, lessthan
  vec_t vecs [9] = '{
    '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0},
    '{16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1},
    '{16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1},
    '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0},
    '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0},
    '{16'h0001, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b0},
    '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1},
    '{16'h1000, 16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0},
    '{16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b1, 1'b0, 1'b0, 1'b1}
  };

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_valid = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on the rising edge of OutValid, data/flags on every DONE cycle.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (OutValid && !prev_valid) begin
        if (sb.size() == 0) chk("spurious_outvalid", 32'(OutValid), 32'd0);
        else                chk("latency", 32'(cyc - sb[0].acc), 32'd4);
      end
      if (OutValid && sb.size() > 0) begin
        chk("D", 32'(D), 32'(sb[0].d));
        chk("Overflow", 32'(Overflow), 32'(sb[0].o));
        chk("Borrow", 32'(Borrow), 32'(sb[0].br));
        chk("InReady_in_done", 32'(InReady), 32'd0);
`ifdef SUB_COMPARE_EN
        chk("Zero", 32'(Zero), 32'(sb[0].z));
        chk("LessThan", 32'(LessThan), 32'(sb[0].lt));
`endif
        if (OutReady) void'(sb.pop_front());
      end
    end
    prev_valid = OutValid;
  end

  task automatic send(input vec_t v, input bit push, input bit hold);
    int   t;
    exp_t e;
    t = 0;
    while (InReady !== 1'b1 && t < 40) begin
      @(posedge Clk); #1;
      t++;
    end
    if (t >= 40) chk("inready_timeout", 32'(InReady), 32'd1);
    A       = v.a;
    B       = v.b;
    InValid = 1'b1;
    @(posedge Clk); #1;
    if (push) begin
      e.d = v.d; e.o = v.o; e.br = v.br; e.z = v.z; e.lt = v.lt; e.acc = cyc;
      sb.push_back(e);
    end
    InValid = hold;
    A       = ~v.a;
    B       = v.a ^ 16'h5A5A;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 60) begin
      @(posedge Clk); #1;
      t++;
    end
    if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int   t;
    vec_t abort_v;
    Rst_n    = 1'b0;
    InValid  = 1'b0;
    A        = '0;
    B        = '0;
    OutReady = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_Overflow", 32'(Overflow), 32'd0);
    chk("rst_Borrow", 32'(Borrow), 32'd0);
    chk("rst_OutValid", 32'(OutValid), 32'd0);
    chk("rst_InReady", 32'(InReady), 32'd1);
`ifdef SUB_COMPARE_EN
    chk("rst_Zero", 32'(Zero), 32'd0);
    chk("rst_LessThan", 32'(LessThan), 32'd0);
`endif
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send(vecs[i], 1'b1, 1'b0);
    drain();

    // Back-pressure: three DONE cycles with OutReady low, InValid held high.
    OutReady = 1'b0;
    send(vecs[4], 1'b1, 1'b1);
    t = 0;
    while (OutValid !== 1'b1 && t < 40) begin
      @(posedge Clk); #1;
      t++;
    end
    if (t >= 40) chk("outvalid_timeout", 32'(OutValid), 32'd1);
    repeat (2) @(posedge Clk);
    #1;
    chk("hold_OutValid", 32'(OutValid), 32'd1);
    OutReady = 1'b1;
    @(posedge Clk); #1;
    chk("idle_InReady", 32'(InReady), 32'd1);
    chk("idle_OutValid", 32'(OutValid), 32'd0);
    chk("idle_D_held", 32'(D), 32'd0);
    InValid = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
    chk("no_second_accept", 32'(InReady), 32'd1);

    for (int i = 5; i < 9; i++) send(vecs[i], 1'b1, 1'b0);
    drain();
    chk("idle_D_last", 32'(D), 32'h4B4B);

    // Abort: reset two cycles into the operation.
    abort_v = '{16'h00FF, 16'h0001, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0};
    send(abort_v, 1'b0, 1'b0);
    @(posedge Clk); #3;
    Rst_n = 1'b0;
    #1;
    chk("abort_D", 32'(D), 32'd0);
    chk("abort_Overflow", 32'(Overflow), 32'd0);
    chk("abort_Borrow", 32'(Borrow), 32'd0);
    chk("abort_OutValid", 32'(OutValid), 32'd0);
    chk("abort_InReady", 32'(InReady), 32'd1);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    chk("post_rst_InReady", 32'(InReady), 32'd1);
    send(vecs[8], 1'b1, 1'b0);
    drain();
    repeat (4) @(posedge Clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/nibble_serial_subtractor.md
NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 SHALL have parameter: l, default 16, operand/result width in bits; legal values are multiples of 4, minimum 8.
REQ-002 SHALL have port: Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: InValid  input  1  operand pair A/B is valid.
REQ-005 SHALL have port: InReady  output  1  block can accept an operand pair.
REQ-006 SHALL have port: A  input  l  minuend, two's complement.
REQ-007 SHALL have port: B  input  l  subtrahend, two's complement.
REQ-008 SHALL have port: OutValid  output  1  result and flags are valid.
REQ-009 SHALL have port: OutReady  input  1  consumer takes the result.
REQ-010 SHALL have port: D  output  l  difference A-B modulo 2^l.
REQ-011 SHALL have port: Overflow  output  1  signed overflow of A-B.
REQ-012 SHALL have port: Borrow  output  1  unsigned borrow out, 1 when A<B unsigned.
REQ-013 SHALL have ports Zero and LessThan (output, 1 bit each) only when SUB_COMPARE_EN is defined (see REQ-031).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: InReady=1, OutValid=0; on a rising edge with InValid=1, SHALL latch A and B, clear the slice counter and borrow-in, and enter RUN.
REQ-016 RUN: InReady=0, OutValid=0; each cycle SHALL compute one 4-bit slice of A-B, LSB slice first, propagating the borrow into the next slice.
REQ-017 After exactly l/4 RUN cycles SHALL enter DONE; OutValid rises l/4 cycles after the accepting edge (4 cycles for l=16).
REQ-018 DONE: OutValid=1, InReady=0; D, Overflow and Borrow SHALL stay stable until handshake completion.
REQ-019 DONE with OutReady=1 at a rising edge SHALL return to IDLE; no new operands are accepted on that same edge.
REQ-020 InValid during RUN or DONE SHALL be ignored, and no operand data SHALL be latched.
REQ-021 A/B changes after acceptance SHALL NOT affect the result.
REQ-022 D SHALL equal (A + ~B + 1) mod 2^l.
REQ-023 Borrow SHALL equal the inverse of the final carry-out of A + ~B + 1.
REQ-024 Overflow SHALL be 1 iff A[l-1] != B[l-1] and D[l-1] != A[l-1].
REQ-025 In IDLE, D and the flags SHALL hold the last delivered result (0 after reset).
REQ-026 OutValid asserted with OutReady already high SHALL complete in the first DONE cycle (one-cycle DONE).

Reset
REQ-027 Rst_n=0 SHALL immediately, without waiting for a clock, force: state IDLE, counter 0, D=0, Overflow=0, Borrow=0, OutValid=0, InReady=1, and Zero=0, LessThan=0 where present.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation; no result SHALL be delivered for it.
REQ-029 The first rising edge after Rst_n deasserts SHALL be able to accept operands.

Configuration
REQ-030 The macro SUB_COMPARE_EN SHALL select compare-flag support.
REQ-031 With SUB_COMPARE_EN defined: Zero=1 iff D==0; LessThan = D[l-1] XOR Overflow (signed A<B); both are valid with OutValid and have the same hold rules as REQ-018/REQ-025.
REQ-032 Without SUB_COMPARE_EN: Zero and LessThan ports and their logic are absent; all other behaviour is identical.

Verification
REQ-033 l=16, A=0x0005, B=0x0003 -> D=0x0002, Overflow=0, Borrow=0, OutValid 4 cycles after accept.
REQ-034 A=0x0000, B=0x0001 -> D=0xFFFF, Overflow=0, Borrow=1; with SUB_COMPARE_EN also LessThan=1, Zero=0.
REQ-035 A=0x8000, B=0x0001 -> D=0x7FFF, Overflow=1, Borrow=0; A=0x7FFF, B=0xFFFF -> D=0x8000, Overflow=1, Borrow=1.
REQ-036 A=B=0x1234 with OutReady held 0 for 3 DONE cycles, InValid=1 throughout -> D=0x0000 held, InReady=0, no second accept, Zero=1 (SUB_COMPARE_EN); IDLE one edge after OutReady=1.
REQ-037 Rst_n pulsed low 2 cycles after accepting A=0x00FF, B=0x0001 -> outputs immediately 0, OutValid never asserts, InReady=1 after release.
